vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage. It derives a pixel-rate enable from the system clock and scans a configurable H/V raster. It presents the pixel coordinate to the pixel source and drives sync, blank and registered RGB aligned one pixel later. It replaces the fixed 640x480 display block and feeds the VGA DAC pins and the Pong renderer.

Parameters:
CLK_DIV, 2, system clocks per pixel; even, >=2
COUNT_W, 10, width of hcount/vcount
H_DISPLAY, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  raster enable; low holds the block idle
rgb_in  in  3*COLOR_W  pixel colour for current hcount/vcount, {r,g,b}
vga_clk  out  1  pixel clock to the DAC, 50% duty
pix_en  out  1  one-clk strobe, one per pixel period
hcount  out  COUNT_W  stage-0 pixel column
vcount  out  COUNT_W  stage-0 line
line_start  out  1  one-clk strobe at the hcount=0 tick
frame_start  out  1  one-clk strobe at the (0,0) tick
hsync  out  1  stage-1 horizontal sync
vsync  out  1  stage-1 vertical sync
vga_blank_n  out  1  stage-1 active-video flag
r, g, b  out  COLOR_W each  stage-1 colour, zero when blanked

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP, and V_TOTAL likewise. Both must fit in COUNT_W bits.
- Reset or en=0 forces:
  - div=0, hcount=0, vcount=0, vga_clk=0, pix_en=0, line_start=0, frame_start=0.
  - hsync=~H_POL and vsync=~V_POL (deasserted).
  - vga_blank_n=0, r=g=b=0.
  - en=0 acts synchronously; rst acts asynchronously.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered, high for the clk cycle in which div==CLK_DIV-1.
  - vga_clk is registered, high while div>=CLK_DIV/2.
- Raster, on pix_en only:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after V_TOTAL-1.
  - After en rises, the first scanned pixel is (0,0).
- Regions along each axis: display [0,H_DISPLAY), then front porch, then sync, then back porch. Vertical uses the same order.
- Stage 1 is registered on pix_en and sampled from stage-0 counters and rgb_in:
  - active = (hcount<H_DISPLAY) && (vcount<V_DISPLAY); vga_blank_n <= active.
  - hsync <= H_POL when hcount is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC), else ~H_POL.
  - vsync <= V_POL when vcount is in the same window built from the V_ constants, else ~V_POL.
  - r/g/b <= rgb_in fields when active, else 0.
- Latency:
  - Stage-1 outputs lag the coordinate presented on hcount/vcount by exactly one pixel period.
  - rgb_in must be valid for the displayed hcount/vcount before the next pix_en.
- Strobes:
  - line_start = pix_en && hcount==0.
  - frame_start = pix_en && hcount==0 && vcount==0.
  - Both are combinational from registers and last exactly one clk cycle.
- Boundary cases:
  - Last pixel (H_TOTAL-1, V_TOTAL-1) wraps to (0,0) on a single tick.
  - en dropping mid-frame aborts the frame; the next enable restarts at (0,0).
- Only nonblocking assignments in clocked logic; counter widths are never truncated.

Decomposition:
- vga_pkg holds the default timing constants (640x480@60) and the sync polarity encoding.
- One sub-module, vga_axis_counter, is instantiated twice (H and V). It provides count, wrap flag and in-sync/in-display flags.

Test Plan:
1. rst=1 asynchronously mid-line -> all outputs return to reset values immediately; after release with en=1, the first pix_en falls on clk 2 and hcount=0,vcount=0 at that strobe.
2. Defaults, en=1 -> pix_en every 2 clks; hsync goes low while hcount=657 (stage 0 was 656), stays low 96 pixels, high again at hcount=753.
3. Defaults -> vga_blank_n high from hcount=1 through hcount=640 of line 0; low for all lines 480..524; vsync low while stage-0 vcount was 490..491.
4. rgb_in=12'hABC constant -> r=A,g=B,b=C whenever vga_blank_n=1; 0 otherwise.
5. Small config H 8/2/2/2, V 4/1/1/1, CLK_DIV=4 -> frame_start every 14*7*4=392 clks; line_start every 56 clks; vga_clk period 4 clks, 2 high.
6. en deasserted at (300,100), re-enabled 10 clks later -> outputs idle while low; restart at (0,0) with frame_start on the first pix_en.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults (640x480@60), sync polarity encoding and small helpers
// for the VGA raster generator.
package vga_pkg;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_COUNT_W   = 10;
  localparam int DEF_COLOR_W   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef struct packed {
    logic wrap;
    logic in_disp;
    logic in_sync;
  } axis_flags_t;

  function automatic int axis_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  function automatic logic sync_level(input logic pol, input logic in_sync);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the raster generator: enable and colour in, timing and
// registered video out. master = generator, slave = pixel source / DAC side.
interface vga_timing_gen_if #(
  parameter int COUNT_W = 10,
  parameter int COLOR_W = 4
);
  logic                   en;
  logic [3*COLOR_W-1:0]   rgb_in;
  logic                   vga_clk;
  logic                   pix_en;
  logic [COUNT_W-1:0]     hcount;
  logic [COUNT_W-1:0]     vcount;
  logic                   line_start;
  logic                   frame_start;
  logic                   hsync;
  logic                   vsync;
  logic                   vga_blank_n;
  logic [COLOR_W-1:0]     r;
  logic [COLOR_W-1:0]     g;
  logic [COLOR_W-1:0]     b;

  modport master (
    input  en, rgb_in,
    output vga_clk, pix_en, hcount, vcount, line_start, frame_start,
           hsync, vsync, vga_blank_n, r, g, b
  );

  modport slave (
    output en, rgb_in,
    input  vga_clk, pix_en, hcount, vcount, line_start, frame_start,
           hsync, vsync, vga_blank_n, r, g, b
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus region flags derived from
// the display / front porch / sync / back porch lengths.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W       = 10,
  parameter int DISPLAY = 640,
  parameter int FP      = 16,
  parameter int SYNC    = 96,
  parameter int BP      = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        tick_i,
  output logic [W-1:0] count_o,
  output axis_flags_t flags_o
);

  localparam int TOTAL = axis_total(DISPLAY, FP, SYNC, BP);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] DISP_END = W'(DISPLAY);
  localparam logic [W-1:0] SYNC_LO  = W'(DISPLAY + FP);
  // One bit wider so a sync window ending exactly at 2**W still compares correctly.
  localparam logic [W:0]   SYNC_HI  = (W+1)'(DISPLAY + FP + SYNC);

  logic [W-1:0] count_q, count_d;
  logic         wrap;

  assign wrap = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (tick_i) count_d = wrap ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o         = count_q;
  assign flags_o.wrap    = wrap;
  assign flags_o.in_disp = (count_q < DISP_END);
  assign flags_o.in_sync = (count_q >= SYNC_LO) && ({1'b0, count_q} < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V scan counters (stage 0)
// and a registered sync/blank/RGB stage one pixel behind the coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int        CLK_DIV   = DEF_CLK_DIV,
  parameter int        COUNT_W   = DEF_COUNT_W,
  parameter int        H_DISPLAY = DEF_H_DISPLAY,
  parameter int        H_FP      = DEF_H_FP,
  parameter int        H_SYNC    = DEF_H_SYNC,
  parameter int        H_BP      = DEF_H_BP,
  parameter int        V_DISPLAY = DEF_V_DISPLAY,
  parameter int        V_FP      = DEF_V_FP,
  parameter int        V_SYNC    = DEF_V_SYNC,
  parameter int        V_BP      = DEF_V_BP,
  parameter sync_pol_e H_POL     = POL_LOW,
  parameter sync_pol_e V_POL     = POL_LOW,
  parameter int        COLOR_W   = DEF_COLOR_W
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic               en;
  logic [DIV_W-1:0]   div_q, div_d, div_nxt;
  logic               pix_en_q, pix_en_d;
  logic               vga_clk_q, vga_clk_d;

  assign en = bus.en;

  // pix_en and vga_clk are computed from the next divider value so that both
  // registers line up with the div_q they describe.
  always_comb begin
    div_nxt   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    div_d     = '0;
    pix_en_d  = 1'b0;
    vga_clk_d = 1'b0;
    if (en) begin
      div_d     = div_nxt;
      pix_en_d  = (div_nxt == DIV_LAST);
      vga_clk_d = (div_nxt >= DIV_HALF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pix_en_q  <= pix_en_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  logic [COUNT_W-1:0] h_count, v_count;
  axis_flags_t        h_flags, v_flags;
  logic               unused_v_wrap;

  vga_axis_counter #(
    .W(COUNT_W), .DISPLAY(H_DISPLAY), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .clr_i(~en), .tick_i(pix_en_q),
    .count_o(h_count), .flags_o(h_flags)
  );

  vga_axis_counter #(
    .W(COUNT_W), .DISPLAY(V_DISPLAY), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .clr_i(~en), .tick_i(pix_en_q & h_flags.wrap),
    .count_o(v_count), .flags_o(v_flags)
  );

  assign unused_v_wrap = v_flags.wrap;

  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 blank_n_q, blank_n_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 active;

  assign active = h_flags.in_disp && v_flags.in_disp;

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (!en) begin
      hsync_d   = ~H_POL;
      vsync_d   = ~V_POL;
      blank_n_d = 1'b0;
      rgb_d     = '0;
    end else if (pix_en_q) begin
      hsync_d   = sync_level(H_POL, h_flags.in_sync);
      vsync_d   = sync_level(V_POL, v_flags.in_sync);
      blank_n_d = active;
      rgb_d     = active ? bus.rgb_in : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q   <= ~H_POL;
      vsync_q   <= ~V_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.vga_clk     = vga_clk_q;
  assign bus.pix_en      = pix_en_q;
  assign bus.hcount      = h_count;
  assign bus.vcount      = v_count;
  assign bus.line_start  = pix_en_q && (h_count == '0);
  assign bus.frame_start = pix_en_q && (h_count == '0) && (v_count == '0);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign bus.g           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign bus.b           = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny 14x7 raster
// instance, checked pixel by pixel against an independent raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CW = 10;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if #(.COUNT_W(CW), .COLOR_W(KW)) if0 ();
  vga_timing_gen_if #(.COUNT_W(CW), .COLOR_W(KW)) if1 ();

  vga_timing_gen dut0 (.clk(clk), .rst(rst), .bus(if0.master));

  vga_timing_gen #(
    .CLK_DIV(4), .COUNT_W(CW), .COLOR_W(KW),
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  typedef struct packed {
    logic          vclk, pe;
    logic [CW-1:0] hc, vc;
    logic          ls, fs, hs, vs, bn;
    logic [3*KW-1:0] rgb;
  } obs_t;

  typedef struct packed {
    logic hs, vs, bn;
    logic [3*KW-1:0] rgb;
  } exp_t;

  // Per-instance timing, index 0 = defaults, 1 = small raster
  int CD [2] = '{2, 4};
  int HD [2] = '{640, 8};
  int HF [2] = '{16, 2};
  int HS [2] = '{96, 2};
  int HB [2] = '{48, 2};
  int VD [2] = '{480, 4};
  int VF [2] = '{10, 1};
  int VS [2] = '{2, 1};
  int VB [2] = '{33, 1};

  bit   sel;
  obs_t obs;
  exp_t sb [$];
  int   ediv, mh, mv, last_ls, last_fs;
  int   n_cmp = 0;
  int   n_bad = 0;

  always_comb begin
    if (sel)
      obs = {if1.vga_clk, if1.pix_en, if1.hcount, if1.vcount, if1.line_start, if1.frame_start,
             if1.hsync, if1.vsync, if1.vga_blank_n, if1.r, if1.g, if1.b};
    else
      obs = {if0.vga_clk, if0.pix_en, if0.hcount, if0.vcount, if0.line_start, if0.frame_start,
             if0.hsync, if0.vsync, if0.vga_blank_n, if0.r, if0.g, if0.b};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model restarts from the idle state: stage 1 still shows idle values at the first tick.
  task automatic restart();
    exp_t e;
    sb.delete();
    e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.rgb = '0;
    sb.push_back(e);
    mh = 0; mv = 0; ediv = 0; last_ls = -1; last_fs = -1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_pix_en"}, obs.pe, 1'b0);
    chk({tag, "_vga_clk"}, obs.vclk, 1'b0);
    chk({tag, "_hcount"}, obs.hc, 0);
    chk({tag, "_vcount"}, obs.vc, 0);
    chk({tag, "_line_start"}, obs.ls, 1'b0);
    chk({tag, "_frame_start"}, obs.fs, 1'b0);
    chk({tag, "_hsync"}, obs.hs, 1'b1);
    chk({tag, "_vsync"}, obs.vs, 1'b1);
    chk({tag, "_blank_n"}, obs.bn, 1'b0);
    chk({tag, "_rgb"}, obs.rgb, 0);
  endtask

  // Advance to the next pixel tick, checking the divider outputs on the way,
  // then check stage 0, pop/compare stage 1 and push the expectation for this pixel.
  task automatic pix(input logic [3*KW-1:0] color);
    int   ht, vt, cd;
    bit   act;
    exp_t e;
    cd = CD[sel];
    ht = HD[sel] + HF[sel] + HS[sel] + HB[sel];
    vt = VD[sel] + VF[sel] + VS[sel] + VB[sel];
    do begin
      @(negedge clk);
      ediv = (ediv + 1) % cd;
      chk("vga_clk", obs.vclk, ediv >= cd / 2);
      chk("pix_en", obs.pe, ediv == cd - 1);
    end while (ediv != cd - 1);

    chk("hcount", obs.hc, mh);
    chk("vcount", obs.vc, mv);
    chk("line_start", obs.ls, mh == 0);
    chk("frame_start", obs.fs, (mh == 0) && (mv == 0));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("hsync", obs.hs, e.hs);
      chk("vsync", obs.vs, e.vs);
      chk("blank_n", obs.bn, e.bn);
      chk("rgb", obs.rgb, e.rgb);
    end
    if (mh == 0) begin
      if (last_ls >= 0) chk("line_period", cyc - last_ls, cd * ht);
      last_ls = cyc;
      if (mv == 0) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, cd * ht * vt);
        last_fs = cyc;
      end
    end

    if (sel) if1.rgb_in = color;
    else     if0.rgb_in = color;
    act   = (mh < HD[sel]) && (mv < VD[sel]);
    e.hs  = !((mh >= HD[sel] + HF[sel]) && (mh < HD[sel] + HF[sel] + HS[sel]));
    e.vs  = !((mv >= VD[sel] + VF[sel]) && (mv < VD[sel] + VF[sel] + VS[sel]));
    e.bn  = act;
    e.rgb = act ? color : '0;
    sb.push_back(e);

    mh++;
    if (mh == ht) begin
      mh = 0;
      mv++;
      if (mv == vt) mv = 0;
    end
  endtask

  initial begin
    sel        = 1'b0;
    if0.en     = 1'b1;
    if1.en     = 1'b0;
    if0.rgb_in = '0;
    if1.rgb_in = '0;
    restart();

    // Reset state, then release with en=1: first tick right after one clock
    repeat (3) @(negedge clk);
    idle_chk("por");
    rst = 1'b0;
    restart();

    // Default raster: full line 0 plus the start of line 1
    repeat (400) pix(12'($urandom));
    repeat (450) pix(12'hABC);

    // Asynchronous reset mid-line
    #2 rst = 1'b1;
    #1 idle_chk("async_rst");
    @(negedge clk);
    rst = 1'b0;
    restart();

    // Scan into line 1 and drop en around column 300
    while (!(mh == 300 && mv == 1)) pix(12'($urandom));
    if0.en = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      idle_chk("en_low");
    end
    if0.en = 1'b1;
    restart();
    repeat (30) pix(12'($urandom));

    // Small raster: two whole frames for vertical regions and strobe periods
    if0.en = 1'b0;
    sel    = 1'b1;
    if1.en = 1'b1;
    restart();
    repeat (14 * 7 * 2 + 3) pix(12'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
